// File: rtl/sudoku_game_ctrl_if.sv
// Command/status bundle between the Sudoku game controller and its surroundings.
// The master side is the controller; the slave side is the debouncer, datapath and checker.
interface sudoku_game_ctrl_if #(
   parameter int WRONG_W = 2
);
   logic               enter;
   logic               back;
   logic               check_done;
   logic               correct;
   logic               solved;
   logic [3:0]         state;
   logic               gen_rand_flag;
   logic               set_board_flag;
   logic               set_diff_flag;
   logic               cell_flag;
   logic               val_flag;
   logic               check_flag;
   logic [WRONG_W-1:0] wrong_count;
   logic               timeout_err;

   modport master (
      input  enter, back, check_done, correct, solved,
      output state, gen_rand_flag, set_board_flag, set_diff_flag,
             cell_flag, val_flag, check_flag, wrong_count, timeout_err
   );

   modport slave (
      output enter, back, check_done, correct, solved,
      input  state, gen_rand_flag, set_board_flag, set_diff_flag,
             cell_flag, val_flag, check_flag, wrong_count, timeout_err
   );
endinterface

// File: rtl/sudoku_game_ctrl.sv
// Sudoku game sequencer: walks the player from board generation to WIN/LOSE and
// issues registered one-cycle command pulses to the board datapath and checker.
module sudoku_game_ctrl #(
   parameter int MAX_WRONG     = 3,
   parameter int WRONG_W       = 2,
   parameter int CHECK_TIMEOUT = 15,
   parameter int TO_W          = 4
) (
   input  logic              clka,
   input  logic              restart,
   sudoku_game_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      IDLE        = 4'd0,
      SET_BOARD   = 4'd1,
      SET_DIFF    = 4'd2,
      CHOOSE_CELL = 4'd3,
      CHOOSE_VAL  = 4'd4,
      CHECKING    = 4'd5,
      WRONG       = 4'd6,
      WIN         = 4'd7,
      LOSE        = 4'd8
   } state_t;

   localparam logic [WRONG_W-1:0] MAX_W     = WRONG_W'(MAX_WRONG);
   localparam logic [WRONG_W-1:0] WRONG_SAT = '1;
   // The count reaching CHECK_TIMEOUT is detected one step early so the exit lands on that cycle.
   localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(CHECK_TIMEOUT - 1);

   state_t             state_q, state_d;
   logic               enter_q, back_q;
   logic               enter_rise, back_rise;
   logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
   logic [WRONG_W-1:0] wrong_q, wrong_d;
   logic               timeout_q, timeout_d;
   logic               gen_q, gen_d;
   logic               sb_q, sb_d;
   logic               sd_q, sd_d;
   logic               cell_q, cell_d;
   logic               val_q, val_d;
   logic               chk_q, chk_d;

   assign enter_rise = bus.enter & ~enter_q;
   assign back_rise  = bus.back  & ~back_q;

   always_comb begin
      state_d   = state_q;
      to_cnt_d  = '0;
      wrong_d   = wrong_q;
      timeout_d = timeout_q;
      sb_d      = 1'b0;
      sd_d      = 1'b0;
      cell_d    = 1'b0;
      val_d     = 1'b0;
      chk_d     = 1'b0;
      case (state_q)
         IDLE:        if (enter_rise) state_d = SET_BOARD;
         SET_BOARD:   if (enter_rise) begin state_d = SET_DIFF;    sb_d   = 1'b1; end
         SET_DIFF:    if (enter_rise) begin state_d = CHOOSE_CELL; sd_d   = 1'b1; end
         CHOOSE_CELL: if (enter_rise) begin state_d = CHOOSE_VAL;  cell_d = 1'b1; end
         CHOOSE_VAL: begin
            if (enter_rise) begin
               state_d = CHECKING;
               val_d   = 1'b1;
               chk_d   = 1'b1;
            end else if (back_rise) begin
               state_d = CHOOSE_CELL;
            end
         end
         CHECKING: begin
            if (bus.check_done) begin
               if (bus.solved) begin
                  state_d = WIN;
               end else if (bus.correct) begin
                  state_d = CHOOSE_CELL;
               end else begin
                  state_d = WRONG;
                  if (wrong_q != WRONG_SAT) wrong_d = wrong_q + WRONG_W'(1);
               end
            end else if (to_cnt_q == TO_LAST) begin
               state_d   = WRONG;
               timeout_d = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         WRONG: begin
            if (wrong_q >= MAX_W)  state_d = LOSE;
            else if (enter_rise)   state_d = CHOOSE_CELL;
         end
         WIN, LOSE: state_d = state_q;
         default:   state_d = IDLE;
      endcase
      gen_d = (state_d == IDLE);
   end

   always_ff @(posedge clka) begin
      if (restart) begin
         state_q   <= IDLE;
         enter_q   <= 1'b0;
         back_q    <= 1'b0;
         to_cnt_q  <= '0;
         wrong_q   <= '0;
         timeout_q <= 1'b0;
         gen_q     <= 1'b1;
         sb_q      <= 1'b0;
         sd_q      <= 1'b0;
         cell_q    <= 1'b0;
         val_q     <= 1'b0;
         chk_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         enter_q   <= bus.enter;
         back_q    <= bus.back;
         to_cnt_q  <= to_cnt_d;
         wrong_q   <= wrong_d;
         timeout_q <= timeout_d;
         gen_q     <= gen_d;
         sb_q      <= sb_d;
         sd_q      <= sd_d;
         cell_q    <= cell_d;
         val_q     <= val_d;
         chk_q     <= chk_d;
      end
   end

   assign bus.state          = state_q;
   assign bus.gen_rand_flag  = gen_q;
   assign bus.set_board_flag = sb_q;
   assign bus.set_diff_flag  = sd_q;
   assign bus.cell_flag      = cell_q;
   assign bus.val_flag       = val_q;
   assign bus.check_flag     = chk_q;
   assign bus.wrong_count    = wrong_q;
   assign bus.timeout_err    = timeout_q;

endmodule

// File: tb/tb_sudoku_game_ctrl.sv
// Scoreboard bench for sudoku_game_ctrl: each driven cycle queues its hand-derived
// expected outputs, which a monitor pops and checks after the following clock edge.
module tb_sudoku_game_ctrl;

   logic clka = 1'b0;
   logic restart;

   sudoku_game_ctrl_if #(.WRONG_W(2)) bus ();

   sudoku_game_ctrl #(
      .MAX_WRONG(3), .WRONG_W(2), .CHECK_TIMEOUT(15), .TO_W(4)
   ) dut (
      .clka    (clka),
      .restart (restart),
      .bus     (bus)
   );

   always #5 clka = ~clka;

   // flag vector order: {gen_rand, set_board, set_diff, cell, val, check}
   localparam logic [5:0] F_IDLE = 6'b100000;
   localparam logic [5:0] F_NONE = 6'b000000;
   localparam logic [5:0] F_SB   = 6'b010000;
   localparam logic [5:0] F_SD   = 6'b001000;
   localparam logic [5:0] F_CELL = 6'b000100;
   localparam logic [5:0] F_VC   = 6'b000011;

   typedef struct {
      string      tag;
      logic [3:0] st;
      logic [5:0] fl;
      logic [1:0] wc;
      logic       te;
   } exp_t;

   exp_t       sb[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [1:0] cur_wc  = 2'd0;
   logic       cur_te  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_tests++;
      if (obs !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic step(input logic rs, input logic e, input logic b, input logic cd,
                       input logic cor, input logic sol, input logic [3:0] st,
                       input logic [5:0] fl, input string tag);
      exp_t x;
      @(negedge clka);
      restart        = rs;
      bus.enter      = e;
      bus.back       = b;
      bus.check_done = cd;
      bus.correct    = cor;
      bus.solved     = sol;
      x.tag = tag;
      x.st  = st;
      x.fl  = fl;
      x.wc  = cur_wc;
      x.te  = cur_te;
      sb.push_back(x);
   endtask

   task automatic idle(input logic [3:0] st, input string tag);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, st, F_NONE, tag);
   endtask

   task automatic ent(input logic [3:0] st, input logic [5:0] fl, input string tag);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, st, fl, tag);
   endtask

   // restart and walk to CHOOSE_CELL with enter released
   task automatic boot();
      cur_wc = 2'd0;
      cur_te = 1'b0;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, F_IDLE, "rst");
      ent(4'd1, F_NONE, "to_board"); idle(4'd1, "board");
      ent(4'd2, F_SB,   "to_diff");  idle(4'd2, "diff");
      ent(4'd3, F_SD,   "to_cell");  idle(4'd3, "cell");
   endtask

   task automatic cell_to_check();
      ent(4'd4, F_CELL, "to_val"); idle(4'd4, "val");
      ent(4'd5, F_VC,   "to_check");
   endtask

   task automatic wrong_to_cell();
      ent(4'd3, F_NONE, "wrong_to_cell"); idle(4'd3, "cell2");
   endtask

   task automatic wait_check(input int n);
      for (int i = 0; i < n; i++) idle(4'd5, "checking");
   endtask

   initial begin
      exp_t x;
      forever begin
         @(posedge clka);
         #1;
         if (sb.size() != 0) begin
            x = sb.pop_front();
            chk({x.tag, "/state"}, 32'(bus.state), 32'(x.st));
            chk({x.tag, "/flags"}, 32'({bus.gen_rand_flag, bus.set_board_flag, bus.set_diff_flag,
                                        bus.cell_flag, bus.val_flag, bus.check_flag}), 32'(x.fl));
            chk({x.tag, "/wrong"}, 32'(bus.wrong_count), 32'(x.wc));
            chk({x.tag, "/tmo"},   32'(bus.timeout_err), 32'(x.te));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      restart        = 1'b1;
      bus.enter      = 1'b0;
      bus.back       = 1'b0;
      bus.check_done = 1'b0;
      bus.correct    = 1'b0;
      bus.solved     = 1'b0;

      // happy path to WIN, WIN is terminal
      boot();
      cell_to_check();
      wait_check(2);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd7, F_NONE, "win");
      ent(4'd7, F_NONE, "win_hold"); idle(4'd7, "win_idle"); ent(4'd7, F_NONE, "win_hold2");

      // held enter in IDLE advances exactly once
      cur_wc = 2'd0; cur_te = 1'b0;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, F_IDLE, "rst_hold");
      for (int i = 0; i < 10; i++) ent(4'd1, F_NONE, "enter_held");
      idle(4'd1, "enter_release");

      // back path, ignored check_done, simultaneous enter+back, correct path
      boot();
      ent(4'd4, F_CELL, "to_val"); idle(4'd4, "val");
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, F_NONE, "back");
      idle(4'd3, "back_release");
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, F_NONE, "cd_ignored");
      ent(4'd4, F_CELL, "to_val2"); idle(4'd4, "val2");
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, F_VC, "enter_wins");
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, F_NONE, "correct");

      // three wrong guesses lead to LOSE
      boot();
      cell_to_check();
      cur_wc = 2'd1;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6, F_NONE, "wrong1");
      wrong_to_cell(); cell_to_check();
      cur_wc = 2'd2;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6, F_NONE, "wrong2");
      wrong_to_cell(); cell_to_check();
      cur_wc = 2'd3;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6, F_NONE, "wrong3");
      idle(4'd8, "lose");
      ent(4'd8, F_NONE, "lose_enter"); idle(4'd8, "lose_idle"); ent(4'd8, F_NONE, "lose_enter2");
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd8, F_NONE, "lose_cd");

      // check_done on the 15th cycle wins over timeout; silence for 15 cycles times out
      boot();
      cell_to_check();
      wait_check(14);
      cur_wc = 2'd1;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6, F_NONE, "cd_at_15");
      wrong_to_cell(); cell_to_check();
      wait_check(14);
      cur_te = 1'b1;
      idle(4'd6, "timeout");
      wrong_to_cell(); cell_to_check();
      cur_wc = 2'd2;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6, F_NONE, "wrong_after_to");
      wrong_to_cell(); cell_to_check();
      wait_check(1);
      cur_wc = 2'd0; cur_te = 1'b0;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, F_IDLE, "restart_midcheck");

      // solved honoured even when correct is low
      boot();
      cell_to_check();
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd7, F_NONE, "solved_no_correct");

      repeat (2) @(posedge clka);
      #2;
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
